// File: rtl/spi_pkg.sv
// Shared SPI FIFO defaults and pointer-width helper, used by the TX and RX
// FIFO instances of the AXI-SPI top.
package spi_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  // One extra MSB beyond the address lets the pointers tell full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_fifo_mem.sv
// FIFO storage: DEPTH x DATA_W, one synchronous write port and one
// asynchronous read port; deliberately not reset.
module spi_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/spi_fifo.sv
// Synchronous first-word-fall-through FIFO with registered status flags,
// threshold flags, occupancy level and sticky overflow/underflow errors.
module spi_fifo
  import spi_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic                      flush,
  input  logic                      push,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      pop,
  output logic [DATA_W-1:0]         rd_data,
  input  logic                      clr_err,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] level_r;
  logic [PW-1:0] level_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic          afull_r;
  logic          aempty_r;
  logic          ovf_r;
  logic          udf_r;
  logic          do_push_s;
  logic          do_pop_s;
  logic          ovf_set_s;
  logic          udf_set_s;

  // A push on a full FIFO is still accepted when the head is popped alongside.
  assign do_push_s = !flush && push && (!full_r || pop);
  assign do_pop_s  = !flush && pop && !empty_r;
  assign ovf_set_s = !flush && push && full_r && !pop;
  assign udf_set_s = !flush && pop && empty_r;

  spi_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (s_axi_aclk),
    .we    (do_push_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (rd_data)
  );

  // Next occupancy; flush wins over any push/pop in the same cycle.
  always_comb begin
    level_nxt_s = level_r;
    if (flush) begin
      level_nxt_s = {PW{1'b0}};
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   level_nxt_s = level_r + {{(PW-1){1'b0}}, 1'b1};
        2'b01:   level_nxt_s = level_r - {{(PW-1){1'b0}}, 1'b1};
        default: level_nxt_s = level_r;
      endcase
    end
  end

  // Pointers, level, status flags and sticky errors.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {PW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
      end else begin
        if (do_push_s) wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
        if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      level_r  <= level_nxt_s;
      full_r   <= (level_nxt_s == PW'(DEPTH));
      empty_r  <= (level_nxt_s == {PW{1'b0}});
      afull_r  <= (level_nxt_s >= PW'(AFULL_TH));
      aempty_r <= (level_nxt_s <= PW'(AEMPTY_TH));
      // A new error in the same cycle as clr_err keeps the flag set.
      ovf_r    <= (ovf_r && !clr_err) || ovf_set_s;
      udf_r    <= (udf_r && !clr_err) || udf_set_s;
    end
  end

  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = afull_r;
  assign almost_empty = aempty_r;
  assign level        = level_r;
  assign overflow     = ovf_r;
  assign underflow    = udf_r;

endmodule

// File: tb/tb_spi_fifo.sv
// Table-driven bench for spi_fifo (DATA_W=8, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1)
// plus hand-written wrap-around and asynchronous reset sequences.
module tb_spi_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       push = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       pop = 1'b0;
  logic [7:0] rd_data;
  logic       clr_err = 1'b0;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] level;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       fl, pu, po, ce;
    logic [7:0] wd;
    logic [2:0] lvl;
    logic       fu, em, af, ae, ov, un;
    logic [7:0] rd;
  } vec_t;

  vec_t vq[$];

  spi_fifo #(.DATA_W(8), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .flush         (flush),
    .push          (push),
    .wr_data       (wr_data),
    .pop           (pop),
    .rd_data       (rd_data),
    .clr_err       (clr_err),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .level         (level),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic fl, pu, po, ce, input logic [7:0] wd,
                     input logic [2:0] lvl, input logic fu, em, af, ae, ov, un,
                     input logic [7:0] rd);
    vec_t v;
    v.fl = fl; v.pu = pu; v.po = po; v.ce = ce; v.wd = wd;
    v.lvl = lvl; v.fu = fu; v.em = em; v.af = af; v.ae = ae;
    v.ov = ov; v.un = un; v.rd = rd;
    vq.push_back(v);
  endtask

  task automatic step(input logic fl, pu, po, ce, input logic [7:0] wd);
    flush = fl; push = pu; pop = po; clr_err = ce; wr_data = wd;
    @(posedge clk);
    #1;
    flush = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_flags"}, {26'd0, full, empty, almost_full, almost_empty, overflow, underflow},
        {26'd0, 6'b010100});
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].fl, vq[i].pu, vq[i].po, vq[i].ce, vq[i].wd);
      chk($sformatf("%s[%0d]_level", tag, i), 32'(level), 32'(vq[i].lvl));
      chk($sformatf("%s[%0d]_flags", tag, i),
          {26'd0, full, empty, almost_full, almost_empty, overflow, underflow},
          {26'd0, vq[i].fu, vq[i].em, vq[i].af, vq[i].ae, vq[i].ov, vq[i].un});
      if (!vq[i].em) chk($sformatf("%s[%0d]_rd", tag, i), 32'(rd_data), 32'(vq[i].rd));
    end
    vq.delete();
  endtask

  initial begin
    #22;
    chk_reset_vals("por");
    rst_n = 1'b1;
    #1;

    // fill, overflow, push+pop on full, drain, clear, empty corner
    //   fl    pu    po    ce    wd      lvl   fu    em    af    ae    ov    un    rd
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'hA0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    run_table("basic");

    // wrap-around: pointers cycle through all slots several times
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'(i));
      chk($sformatf("wrap%0d_rd", i), 32'(rd_data), 32'(i));
      chk($sformatf("wrap%0d_lvl1", i), 32'(level), 32'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk($sformatf("wrap%0d_lvl0", i), 32'(level), 32'd0);
    end

    // flush with push at level 3, errors preserved
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h99, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    // reach level 2 with overflow set
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'hC1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'hC2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'hC3, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'hC4, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'hC5, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC2);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3);
    run_table("flush");

    // asynchronous reset between edges takes effect before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    // push held across an edge while in reset must not take effect
    push = 1'b1; wr_data = 8'hEE;
    @(posedge clk);
    #1;
    chk_reset_vals("hold");
    push = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_reset_vals("release");

    // clr_err together with an overflowing push keeps overflow set
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'hD1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hD1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'hD2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hD1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'hD3, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hD1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'hD4, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hD1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'hD5, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hD1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 8'hD6, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hD1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hD1);
    run_table("clrerr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_fifo.md
SPI_FIFO -- requirements
Module: spi_fifo

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits, legal range 1..32.
REQ-002 Parameter DEPTH, default 16: number of entries, a power of two, legal range 4..256.
REQ-003 Parameter AFULL_TH, default DEPTH-2: almost_full asserts when level >= AFULL_TH.
REQ-004 Parameter AEMPTY_TH, default 2: almost_empty asserts when level <= AEMPTY_TH.
REQ-005 Port s_axi_aclk, in, 1: single clock; all state changes on its rising edge.
REQ-006 Port s_axi_aresetn, in, 1: asynchronous, active-low reset.
REQ-007 Port flush, in, 1: synchronous discard of all contents.
REQ-008 Port push, in, 1: write request.
REQ-009 Port wr_data, in, DATA_W: write word.
REQ-010 Port pop, in, 1: read request.
REQ-011 Port rd_data, out, DATA_W: head word; first-word-fall-through.
REQ-012 Port clr_err, in, 1: clears the sticky error flags.
REQ-013 Port full / empty, out, 1 each: status flags.
REQ-014 Port almost_full / almost_empty, out, 1 each: threshold flags.
REQ-015 Port level, out, clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-016 Port overflow / underflow, out, 1 each: sticky error flags.

Function
REQ-017 Write and read pointers shall be clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; the MSB distinguishes full from empty.
REQ-018 full = (level == DEPTH), empty = (level == 0); all flags and level are registered or derived only from registered pointers, with no path from push or pop.
REQ-019 rd_data shall present mem[rd_ptr] combinationally whenever empty=0; its value is don't-care when empty=1.
REQ-020 A push with full=0 shall write wr_data and advance wr_ptr by 1 at the edge; the new word is visible at rd_data one cycle later when the FIFO was empty.
REQ-021 A pop with empty=0 shall advance rd_ptr by 1 at the edge.
REQ-022 A push while full=1 and pop=0 shall be dropped and set overflow.
REQ-023 A push and a pop in the same cycle while full=1 shall both be accepted; level stays DEPTH, and the overwritten slot is the one being popped.
REQ-024 A pop while empty=1 shall be ignored and set underflow; a push in the same cycle is still accepted and level becomes 1.
REQ-025 A push and a pop in the same cycle while the FIFO is neither full nor empty shall both be accepted with level unchanged.
REQ-026 level shall update in the same edge as the pointers: +1 for push only, -1 for pop only, 0 for both or neither.
REQ-027 flush shall set wr_ptr = rd_ptr = 0 and level = 0 at the edge and takes priority over push and pop in that cycle; memory contents are not cleared.
REQ-028 overflow and underflow, once set, shall hold until clr_err or reset; if clr_err and a new error occur in the same cycle, the flag remains set.
REQ-029 flush shall not clear overflow or underflow.

Reset
REQ-030 Asserting s_axi_aresetn low shall immediately set both pointers to 0, level=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0 and underflow=0.
REQ-031 Reset asserted mid-operation shall discard all contents, and no push or pop shall take effect at the edge on which reset is released.
REQ-032 The memory array shall have no reset.

Structure
REQ-033 A shared package spi_pkg shall hold the default DATA_W and DEPTH constants and a function that computes the pointer width; the AXI-SPI top shall use them to instantiate separate TX and RX FIFOs.
REQ-034 One sub-module, spi_fifo_mem (DEPTH x DATA_W, one write port and one asynchronous read port, no reset), shall hold the storage; all control logic stays in spi_fifo.

Verification (DATA_W=8, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1)
REQ-035 Fill to full: push 0x11, 0x22, 0x33, 0x44 -> full=1, level=4, almost_full asserted at level 3; a fifth push of 0x55 sets overflow, and pops then return 0x11..0x44.
REQ-036 Simultaneous push and pop on full: push 0xA0 with a pop -> rd_data was 0x11, level stays 4, and subsequent pops return 0x22, 0x33, 0x44, 0xA0.
REQ-037 Empty corner: pop with push of 0x5A on an empty FIFO -> underflow=1, level=1, rd_data=0x5A on the next cycle.
REQ-038 Wrap-around: 10 cycles of alternating push/pop with data 0x00..0x09 -> every pop returns the data in order and level never exceeds 1.
REQ-039 Flush with push in the same cycle at level 3 -> level=0 and empty=1 on the next cycle, error flags unchanged; a following push of 0x77 reads back as 0x77.
REQ-040 Asynchronous reset asserted between clock edges at level 2 with overflow=1 -> all outputs take their reset values before the next edge; clr_err asserted together with an overflowing push leaves overflow=1.
